fetch_pipeline_ctrl: RTL and testbench
======================================

# fetch_pipeline_ctrl

Fetch-stage sequential block that consumes the hazard unit's `PCWrite`, `IF_ID_Write`, `stall` and `IF_Flush` outputs. It owns the PC register, selects the next PC (sequential, ID-resolved branch, jump) and holds the IF/ID pipeline register with hold and flush semantics. It drives the ID/EX bubble select and keeps saturating stall and flush performance counters. It sits between instruction memory and the ID stage of the 5-stage MIPS pipeline.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0000, instruction word inserted into IF/ID on flush
- `CNT_W`, 16, width of the performance counters

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `PCWrite`  in  1  1 = PC may update; 0 = hold PC
- `IF_ID_Write`  in  1  1 = IF/ID may load or flush; 0 = hold IF/ID
- `stall`  in  1  hazard unit bubble request
- `IF_Flush`  in  1  hazard unit flush request
- `branch_taken`  in  1  branch resolved taken in ID this cycle
- `branch_target`  in  32  branch destination
- `jump`  in  1  jump decoded in ID this cycle
- `jump_target`  in  32  jump destination
- `instr_in`  in  32  instruction memory read data for current `pc`
- `pc`  out  32  current fetch address
- `IF_ID_PC4`  out  32  registered PC+4 of the instruction in ID
- `IF_ID_Instr`  out  32  registered instruction in ID
- `IF_ID_Valid`  out  1  0 = IF/ID holds an inserted NOP
- `ID_EX_Bubble`  out  1  1 = ID stage must zero control signals into ID/EX
- `stall_cycles`  out  CNT_W  count of cycles with `stall`=1
- `flush_count`  out  CNT_W  count of IF/ID flush events

## Operation
- `redirect` = (`branch_taken` | `jump`) & ~`stall`. Redirects requested during a stall are ignored. ID re-presents them after the stall clears.
- Next PC is evaluated in priority order:
  - `PCWrite`=0: `pc` is held.
  - `branch_taken` & ~`stall`: `branch_target` & ~32'h3.
  - `jump` & ~`stall`: `jump_target` & ~32'h3.
  - Otherwise: `pc`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0).
- Branch wins over jump when both are asserted.
- IF/ID update, in priority order:
  - `IF_ID_Write`=0: all IF/ID fields are held. `IF_Flush` is ignored in that cycle. A flush never destroys a stalled instruction.
  - `IF_Flush` | `redirect`: `IF_ID_Instr`←`NOP_INSTR`, `IF_ID_Valid`←0, `IF_ID_PC4`←`pc`+4.
  - Otherwise: `IF_ID_Instr`←`instr_in`, `IF_ID_PC4`←`pc`+4, `IF_ID_Valid`←1.
- `ID_EX_Bubble` is combinational and equals `stall` | ~`IF_ID_Valid`.
- `stall_cycles` increments on every cycle with `stall`=1.
- `flush_count` increments on every cycle in which the flush branch of the IF/ID update is taken.
- Both counters saturate at all-ones and never wrap.
- There is no FSM beyond this register state. Mode is fully determined by the current inputs.

## Timing
- Reset is synchronous. On a `clk` edge with `reset`=1:
  - `pc`←`PC_RESET`, `IF_ID_Instr`←`NOP_INSTR`, `IF_ID_PC4`←0, `IF_ID_Valid`←0.
  - Both counters ←0.
- Reset overrides every other input, including mid-stall and mid-redirect.
- After reset deasserts, `ID_EX_Bubble`=1 until the first fetched instruction is loaded.
- Taken branch or jump latency: the target appears on `pc` one edge after `redirect`. Exactly one NOP is inserted (the wrong-path instruction is squashed at that same edge).
- Load-use stall (`PCWrite`=`IF_ID_Write`=0, `stall`=1) for N cycles:
  - `pc` and IF/ID are frozen for N edges.
  - `ID_EX_Bubble`=1 for those N cycles.
  - `stall_cycles` increases by N.
- `PCWrite`=1 with `IF_ID_Write`=0 is legal: PC advances while IF/ID holds.
- `PCWrite`=0 with `IF_ID_Write`=1 is legal: IF/ID reloads the same `pc`.
- All outputs except `ID_EX_Bubble` are registered. No combinational path runs from inputs to registered outputs.

## Test plan
- Reset, then 3 free-running cycles, `instr_in`=0x2000_0001/2/3 -> `pc`=0x0,0x4,0x8,0xC. `IF_ID_Instr` lags one cycle. `IF_ID_Valid`=1 from cycle 2. Counters=0.
- Load-use: at `pc`=0x10, drive `stall`=1 and `PCWrite`=`IF_ID_Write`=0 for 1 cycle with `IF_Flush`=1 -> `pc` stays 0x10 and IF/ID is unchanged. Then `stall_cycles`=1, `flush_count`=0, and the next cycle resumes at 0x14.
- Taken branch at `pc`=0x20, `branch_target`=0x100, with `jump`=1 and `jump_target`=0x200 simultaneously -> next `pc`=0x100, `IF_ID_Instr`=NOP, `IF_ID_Valid`=0, `flush_count`=1.
- Branch during stall: `branch_taken`=1 with `stall`=1 for 2 cycles, then `stall`=0 -> PC is held 2 cycles, then `pc`=target on the following edge. `stall_cycles`=2.
- Wrap and alignment: `pc`=0xFFFF_FFFC free-running -> 0x0000_0000. `jump_target`=0x0000_0043 -> `pc`=0x0000_0040.
- Saturation and reset: `CNT_W`=4 with `stall` held 20 cycles -> `stall_cycles`=0xF. Assert `reset` mid-stall -> all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch-stage control: PC register, next-PC select, IF/ID register with hold/flush,
// ID/EX bubble select and saturating stall/flush performance counters.
module fetch_pipeline_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             stall,
    input  logic             IF_Flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      instr_in,
    output logic [31:0]      pc,
    output logic [31:0]      IF_ID_PC4,
    output logic [31:0]      IF_ID_Instr,
    output logic             IF_ID_Valid,
    output logic             ID_EX_Bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic        redirect;
    logic        do_flush;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    // Redirects seen during a stall are dropped; ID re-presents them afterwards.
    assign redirect = (branch_taken | jump) & ~stall;
    assign do_flush = IF_ID_Write & (IF_Flush | redirect);
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        if (!PCWrite) begin
            pc_next = pc;
        end else if (branch_taken && !stall) begin
            pc_next = branch_target & ~32'h3;
        end else if (jump && !stall) begin
            pc_next = jump_target & ~32'h3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= PC_RESET;
            IF_ID_Instr  <= NOP_INSTR;
            IF_ID_PC4    <= 32'h0;
            IF_ID_Valid  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            pc <= pc_next;
            if (IF_ID_Write) begin
                IF_ID_PC4 <= pc_plus4;
                if (IF_Flush || redirect) begin
                    IF_ID_Instr <= NOP_INSTR;
                    IF_ID_Valid <= 1'b0;
                end else begin
                    IF_ID_Instr <= instr_in;
                    IF_ID_Valid <= 1'b1;
                end
            end
            if (stall && stall_cycles != CntMax) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (do_flush && flush_count != CntMax) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign ID_EX_Bubble = stall | ~IF_ID_Valid;

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Directed bench for fetch_pipeline_ctrl; a second instance with 4-bit counters
// exercises counter saturation.
module tb_fetch_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, IF_ID_Write, stall, IF_Flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target, instr_in;
    logic [31:0] pc, IF_ID_PC4, IF_ID_Instr;
    logic        IF_ID_Valid, ID_EX_Bubble;
    logic [15:0] stall_cycles, flush_count;

    logic [31:0] s_pc, s_pc4, s_instr;
    logic        s_valid, s_bubble;
    logic [3:0]  s_stall_cycles, s_flush_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_pipeline_ctrl dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .stall(stall), .IF_Flush(IF_Flush), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .instr_in(instr_in), .pc(pc), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_Valid(IF_ID_Valid), .ID_EX_Bubble(ID_EX_Bubble),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    fetch_pipeline_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .stall(stall), .IF_Flush(IF_Flush), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .instr_in(instr_in), .pc(s_pc), .IF_ID_PC4(s_pc4), .IF_ID_Instr(s_instr),
        .IF_ID_Valid(s_valid), .ID_EX_Bubble(s_bubble),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".instr"}, IF_ID_Instr, e_instr);
        check({tag, ".pc4"}, IF_ID_PC4, e_pc4);
        check({tag, ".valid"}, {31'b0, IF_ID_Valid}, {31'b0, e_valid});
    endtask

    initial begin
        reset = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; stall = 1'b0; IF_Flush = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;
        instr_in = 32'h2000_0000;

        // Reset state
        step();
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.bubble", {31'b0, ID_EX_Bubble}, 32'd1);
        check("reset.stall_cnt", {16'b0, stall_cycles}, 32'd0);
        check("reset.flush_cnt", {16'b0, flush_count}, 32'd0);

        // Free-running fetch
        reset = 1'b0;
        instr_in = 32'h2000_0001; step();
        check_ifid("run1", 32'h4, 32'h2000_0001, 32'h4, 1'b1);
        check("run1.bubble", {31'b0, ID_EX_Bubble}, 32'd0);
        instr_in = 32'h2000_0002; step();
        check_ifid("run2", 32'h8, 32'h2000_0002, 32'h8, 1'b1);
        instr_in = 32'h2000_0003; step();
        check_ifid("run3", 32'hC, 32'h2000_0003, 32'hC, 1'b1);
        instr_in = 32'h2000_0004; step();
        check_ifid("run4", 32'h10, 32'h2000_0004, 32'h10, 1'b1);
        check("run4.stall_cnt", {16'b0, stall_cycles}, 32'd0);

        // Load-use stall with a flush request that must be ignored
        stall = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0; IF_Flush = 1'b1;
        instr_in = 32'hDEAD_BEEF; step();
        check_ifid("lu", 32'h10, 32'h2000_0004, 32'h10, 1'b1);
        check("lu.bubble", {31'b0, ID_EX_Bubble}, 32'd1);
        check("lu.stall_cnt", {16'b0, stall_cycles}, 32'd1);
        check("lu.flush_cnt", {16'b0, flush_count}, 32'd0);
        stall = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_Flush = 1'b0;
        instr_in = 32'h2000_0005; step();
        check_ifid("lu_resume", 32'h14, 32'h2000_0005, 32'h14, 1'b1);

        instr_in = 32'h2000_0006; step();
        instr_in = 32'h2000_0007; step();
        instr_in = 32'h2000_0008; step();
        check("pre_br.pc", pc, 32'h20);

        // Branch and jump together: branch wins, one NOP inserted
        branch_taken = 1'b1; branch_target = 32'h100; jump = 1'b1; jump_target = 32'h200;
        instr_in = 32'h0BAD_0BAD; step();
        check_ifid("br", 32'h100, 32'h0, 32'h24, 1'b0);
        check("br.bubble", {31'b0, ID_EX_Bubble}, 32'd1);
        check("br.flush_cnt", {16'b0, flush_count}, 32'd1);
        branch_taken = 1'b0; jump = 1'b0;
        instr_in = 32'h2000_0010; step();
        check_ifid("br_tgt", 32'h104, 32'h2000_0010, 32'h104, 1'b1);

        // Branch during a 2-cycle stall is deferred
        stall = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h300; step();
        check_ifid("bst1", 32'h104, 32'h2000_0010, 32'h104, 1'b1);
        step();
        check_ifid("bst2", 32'h104, 32'h2000_0010, 32'h104, 1'b1);
        check("bst2.stall_cnt", {16'b0, stall_cycles}, 32'd3);
        check("bst2.flush_cnt", {16'b0, flush_count}, 32'd1);
        stall = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1; step();
        check_ifid("bst3", 32'h300, 32'h0, 32'h108, 1'b0);
        check("bst3.flush_cnt", {16'b0, flush_count}, 32'd2);
        branch_taken = 1'b0;

        // Alignment of jump target and PC wrap
        jump = 1'b1; jump_target = 32'hFFFF_FFFE; step();
        check("jalign.pc", pc, 32'hFFFF_FFFC);
        jump = 1'b0; instr_in = 32'h2000_0020; step();
        check_ifid("wrap", 32'h0, 32'h2000_0020, 32'h0, 1'b1);
        jump = 1'b1; jump_target = 32'h0000_0043; step();
        check("j43.pc", pc, 32'h40);
        check("j43.flush_cnt", {16'b0, flush_count}, 32'd4);
        jump = 1'b0;

        // PCWrite=0, IF_ID_Write=1: IF/ID reloads the same pc
        PCWrite = 1'b0; instr_in = 32'h2000_0030; step();
        check_ifid("pchold", 32'h40, 32'h2000_0030, 32'h44, 1'b1);
        // PCWrite=1, IF_ID_Write=0: PC advances, IF/ID holds
        PCWrite = 1'b1; IF_ID_Write = 1'b0; instr_in = 32'h2000_0031; step();
        check_ifid("ifidhold", 32'h44, 32'h2000_0030, 32'h44, 1'b1);

        // Saturation: 20 more stall cycles
        stall = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat.small", {28'b0, s_stall_cycles}, 32'hF);
        check("sat.main", {16'b0, stall_cycles}, 32'd23);
        check("sat.pc", pc, 32'h44);

        // Reset mid-stall and mid-redirect
        reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h500; step();
        check_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst2.stall_cnt", {16'b0, stall_cycles}, 32'd0);
        check("rst2.flush_cnt", {16'b0, flush_count}, 32'd0);
        check("rst2.small_cnt", {28'b0, s_stall_cycles}, 32'd0);
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        check("rst2.bubble", {31'b0, ID_EX_Bubble}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
